// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI command path.
// Holds the framer state encoding, frame/response lengths and SD command numbers.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRC   = 3'd1,
    ST_PUSH  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam logic [5:0] CMD_LEN   = 6'd6;
  localparam logic [5:0] R1_LEN    = 6'd1;
  localparam logic [5:0] R3_R7_LEN = 6'd5;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;

  // R7 (CMD8) and R3 (CMD58) carry four bytes after the R1 status byte.
  function automatic logic [5:0] resp_len_of(input logic [5:0] idx);
    return ((idx == CMD8) || (idx == CMD58)) ? R3_R7_LEN : R1_LEN;
  endfunction

endpackage

// File: rtl/sd_cmd_framer_if.sv
// Bundle of request, TX-FIFO and SPI-master signals around the command framer.
// Handshake: a request transfers on a clk edge where cmd_valid && cmd_ready.
interface sd_cmd_framer_if;
  import sd_spi_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [9:0]  rx_data_len;
  logic [9:0]  tx_data_len;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full;
  logic        spi_start;
  logic [5:0]  cmd_length;
  logic [5:0]  response_length;
  logic [9:0]  receive_data_length;
  logic [9:0]  send_data_length;
  logic        spi_busy;
  logic        spi_valid;
  logic        done;
  logic        timeout_err;
  state_t      state_dbg;

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, rx_data_len, tx_data_len,
    input  fifo_full, spi_busy, spi_valid,
    output cmd_ready, fifo_wr_en, fifo_wr_data, spi_start, cmd_length,
    output response_length, receive_data_length, send_data_length,
    output done, timeout_err, state_dbg
  );

  modport master (
    output cmd_valid, cmd_index, cmd_arg, rx_data_len, tx_data_len,
    output fifo_full, spi_busy, spi_valid,
    input  cmd_ready, fifo_wr_en, fifo_wr_data, spi_start, cmd_length,
    input  response_length, receive_data_length, send_data_length,
    input  done, timeout_err, state_dbg
  );

endinterface

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), one message bit per enabled cycle, MSB first.
module sd_crc7_serial
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_crc = r_crc;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_crc <= 7'd0;
    end else if (i_en) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'd0);
    end
  end

endmodule

// File: rtl/sd_cmd_framer.sv
// Builds the 6-byte SPI-mode SD command frame, feeds the TX byte FIFO and
// supervises the SPI master transfer (start/busy/valid) with a timeout.
module sd_cmd_framer
  import sd_spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int ARG_W          = 32
) (
  input logic             clk,
  input logic             rst,
  sd_cmd_framer_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [5:0]       r_index;
  logic [ARG_W-1:0] r_arg;
  logic [5:0]       r_bit_cnt;
  logic [2:0]       r_byte_idx;
  logic [TW-1:0]    r_tmo;
  logic             r_cmd_ready;
  logic             r_spi_start;
  logic             r_done;
  logic             r_tmo_err;
  logic [5:0]       r_resp_len;
  logic [9:0]       r_rx_len;
  logic [9:0]       r_tx_len;

  logic [39:0] w_msg;
  logic        w_bit;
  logic [6:0]  w_crc;
  logic [7:0]  w_byte;
  logic        w_tmo_hit;

  assign w_msg     = {2'b01, r_index, r_arg};
  assign w_bit     = w_msg[6'd39 - r_bit_cnt];
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  sd_crc7_serial u_crc (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == ST_IDLE),
    .i_en    (r_state == ST_CRC),
    .i_bit   (w_bit),
    .o_crc   (w_crc)
  );

  always_comb begin
    w_byte = 8'd0;
    case (r_byte_idx)
      3'd0:    w_byte = {2'b01, r_index};
      3'd1:    w_byte = r_arg[31:24];
      3'd2:    w_byte = r_arg[23:16];
      3'd3:    w_byte = r_arg[15:8];
      3'd4:    w_byte = r_arg[7:0];
      3'd5:    w_byte = {w_crc, 1'b1};
      default: w_byte = 8'd0;
    endcase
  end

  // The write strobe must see the current fifo_full, so it is decoded, not registered.
  assign bus.fifo_wr_en          = (r_state == ST_PUSH) && !bus.fifo_full;
  assign bus.fifo_wr_data        = (r_state == ST_PUSH) ? w_byte : 8'd0;
  assign bus.cmd_ready           = r_cmd_ready;
  assign bus.spi_start           = r_spi_start;
  assign bus.cmd_length          = CMD_LEN;
  assign bus.response_length     = r_resp_len;
  assign bus.receive_data_length = r_rx_len;
  assign bus.send_data_length    = r_tx_len;
  assign bus.done                = r_done;
  assign bus.timeout_err         = r_tmo_err;
  assign bus.state_dbg           = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_index     <= 6'd0;
      r_arg       <= '0;
      r_bit_cnt   <= 6'd0;
      r_byte_idx  <= 3'd0;
      r_tmo       <= '0;
      r_cmd_ready <= 1'b1;
      r_spi_start <= 1'b0;
      r_done      <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_resp_len  <= 6'd0;
      r_rx_len    <= 10'd0;
      r_tx_len    <= 10'd0;
    end else begin
      r_done    <= 1'b0;
      r_tmo_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_index     <= bus.cmd_index;
            r_arg       <= bus.cmd_arg;
            r_rx_len    <= bus.rx_data_len;
            r_tx_len    <= bus.tx_data_len;
            r_resp_len  <= resp_len_of(bus.cmd_index);
            r_cmd_ready <= 1'b0;
            r_bit_cnt   <= 6'd0;
            r_state     <= ST_CRC;
          end
        end
        ST_CRC: begin
          if (r_bit_cnt == 6'd39) begin
            r_byte_idx <= 3'd0;
            r_state    <= ST_PUSH;
          end else begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
        end
        ST_PUSH: begin
          if (!bus.fifo_full) begin
            if (r_byte_idx == 3'd5) begin
              r_spi_start <= 1'b1;
              r_tmo       <= '0;
              r_state     <= ST_START;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end
        end
        ST_START: begin
          if (w_tmo_hit) begin
            r_spi_start <= 1'b0;
            r_done      <= 1'b1;
            r_tmo_err   <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (bus.spi_busy) begin
              r_spi_start <= 1'b0;
              r_state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A completion in the same cycle as expiry is reported as success.
          if (bus.spi_valid) begin
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_tmo_hit) begin
            r_done      <= 1'b1;
            r_tmo_err   <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_framer.md
Name: sd_cmd_framer

Overview:
Upstream command stage for the SD-card SPI master.
- Accepts an SD command request (index, 32-bit argument, data lengths).
- Builds the 6-byte SPI-mode command frame, including a serially computed CRC7, and pushes the bytes into the SPI master's transmit byte FIFO.
- Drives the SPI master's length and start inputs, then tracks the transfer through busy/valid to completion, with a timeout.

Parameters:
- TIMEOUT_CYCLES, 2_000_000: clk cycles allowed from start request to SPI valid before error.
- ARG_W, 32: command argument width. Fixed by the SD protocol; not intended to change.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  high only in IDLE
- cmd_index  in  6  SD command number
- cmd_arg  in  32  command argument
- rx_data_len  in  10  data bytes to receive after the response (0 = none)
- tx_data_len  in  10  data bytes to send after the response (0 = none)
- fifo_wr_en  out  1  one-cycle write strobe to the TX byte FIFO
- fifo_wr_data  out  8  byte to write
- fifo_full  in  1  TX FIFO full
- spi_start  out  1  level start request to the SPI master
- cmd_length  out  6  constant 6
- response_length  out  6  response bytes expected
- receive_data_length  out  10  latched rx_data_len
- send_data_length  out  10  latched tx_data_len
- spi_busy  in  1  SPI busy, already synchronised to clk
- spi_valid  in  1  SPI transfer complete, already synchronised to clk
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  one-cycle pulse, coincident with done on timeout

Behaviour:
- Reset values:
  - All outputs 0 except cmd_length=6 and cmd_ready=1.
  - State IDLE; CRC register 0; counters 0.
- Request acceptance (IDLE):
  - Handshake completes when cmd_valid && cmd_ready.
  - On acceptance, latch index, arg and both lengths, then go to CRC.
  - response_length = 5 for cmd_index 8 or 58 (R7/R3); otherwise 1.
- CRC state:
  - Shift the 40-bit message {2'b01, cmd_index, cmd_arg} MSB first, one bit per clk.
  - Polynomial x^7+x^3+1, initial value 0.
  - Per bit: fb = bit ^ crc[6]; crc = {crc[5:0],0} ^ (fb ? 7'h09 : 0).
  - Exactly 40 cycles, then go to PUSH.
- PUSH state:
  - Bytes in order: {01,index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1}.
  - Write one byte per cycle when !fifo_full; when fifo_full, hold fifo_wr_en low and keep the byte index.
  - After byte 5 is written, go to START.
- START state:
  - spi_start held high until spi_busy is sampled high, then go to WAIT.
  - The start is level-held because the SPI master samples on a slow SCK.
  - spi_start drops in the same cycle the state leaves START.
- WAIT state:
  - On spi_valid high, pulse done and return to IDLE.
- Timeout:
  - The counter runs through START and WAIT.
  - At TIMEOUT_CYCLES: deassert spi_start, pulse done and timeout_err, return to IDLE.
  - FIFO contents are not flushed.
- Simultaneous events: if the timeout expires in the same cycle that spi_valid arrives, spi_valid wins (done only, no error).
- Latched lengths hold their value until the next acceptance.
- rst at any time: return to IDLE with reset values in the next cycle; a partially written frame is abandoned.

Decomposition:
- Shared package sd_spi_pkg holds:
  - state enum
  - CMD_LEN=6
  - R1_LEN=1, R3_R7_LEN=5
  - CRC7_POLY=7'h09
  - command-index constants CMD0, CMD8, CMD17, CMD55, ACMD41, CMD58
- One sub-module, sd_crc7_serial: clear, enable, bit-in, 7-bit crc out. It is reused later for data-token handling.

Test Plan:
- CMD0, arg 0 -> FIFO bytes 40 00 00 00 00 95; response_length=1; spi_start held until spi_busy; done after spi_valid.
- CMD8, arg 0x000001AA -> 48 00 00 01 AA 87; response_length=5.
- CMD17 (51 00 00 00 00 55) with rx_data_len=512 -> receive_data_length=512. Then CMD58 (7A 00 00 00 00 FD) -> response_length=5.
- fifo_full asserted for 3 cycles during byte 2 of CMD55 (77 00 00 00 00 65) -> no writes during the stall; byte order intact.
- ACMD41, arg 0x40000000 (69 40 00 00 00 77) with spi_busy never asserted and TIMEOUT_CYCLES=100 -> done and timeout_err pulse 100 cycles after START; cmd_ready=1 the next cycle.
- rst asserted mid-PUSH (after byte 3) -> next cycle all outputs at reset values; a new CMD0 then frames correctly.
